// File: rtl/wb_burst_reader_pkg.sv
// Shared constants and state type for the Wishbone burst reader.
package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    GAP
  } state_t;

endpackage

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 pipelined-less bus with registered-feedback burst tags.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic        ack;
  logic [31:0] dat_sm;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, we, adr, sel, cti, bte, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output ack, dat_sm
  );

endinterface

// File: rtl/wb_burst_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pop on empty is ignored,
// push on full is accepted only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates the output.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone burst reader: fetches word_cnt words from base_adr in
// incrementing bursts of up to BURST_LEN beats into a stream FIFO.
// A burst only starts once the FIFO can absorb all of its beats, so ack
// is never back-pressured.
module wb_burst_reader
  import wb_burst_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  wshb_if.master           wb_m,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int BW  = $clog2(BURST_LEN) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q;
  logic [31:0]      adr_q;
  logic [CNT_W-1:0] rem_q;
  logic [BW-1:0]    beat_q;
  logic             cyc_q;
  logic [2:0]       cti_q;
  logic             busy_q;
  logic             done_q;

  logic [BW-1:0]    blen_d;
  logic [FCW-1:0]   fifo_count;
  logic [FCW-1:0]   fifo_free;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             space_ok;

  assign blen_d    = (rem_q < CNT_W'(BURST_LEN)) ? BW'(rem_q) : BW'(BURST_LEN);
  assign fifo_free = FCW'(FIFO_DEPTH) - fifo_count;
  assign space_ok  = !fifo_full && (fifo_free >= FCW'(blen_d));
  assign fifo_push = (state_q == BURST) && wb_m.ack;

  // Burst sequencer with registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            adr_q <= {base_adr[31:2], 2'b00};
            rem_q <= word_cnt;
            if (word_cnt == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            beat_q  <= blen_d;
            cyc_q   <= 1'b1;
            cti_q   <= (blen_d == BW'(1)) ? CTI_EOB : CTI_INCR;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (wb_m.ack) begin
            adr_q  <= adr_q + 32'd4;
            rem_q  <= rem_q - 1'b1;
            beat_q <= beat_q - 1'b1;
            if (beat_q == BW'(1)) begin
              cyc_q <= 1'b0;
              cti_q <= CTI_CLASSIC;
              if (rem_q == CNT_W'(1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= GAP;
              end
            end else begin
              cti_q <= (beat_q == BW'(2)) ? CTI_EOB : CTI_INCR;
            end
          end
        end
        GAP:     state_q <= WAIT_SPACE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (wb_m.dat_sm),
    .pop_i   (rd_ready),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rd_valid    = !fifo_empty;
  assign busy        = busy_q;
  assign done        = done_q;

  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = cyc_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.adr    = adr_q;
  assign wb_m.sel    = 4'hF;
  assign wb_m.cti    = cti_q;
  assign wb_m.bte    = BTE_LINEAR;
  assign wb_m.dat_ms = '0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: Wishbone slave model, stream consumer and a
// transfer-level reference model (expected words, beats and burst sizes).
module tb_wb_burst_reader;
  import wb_burst_pkg::*;

  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_adr = '0;
  logic [CNT_W-1:0] word_cnt = '0;
  logic             busy, done, rd_valid;
  logic [31:0]      rd_data;
  logic             rd_ready = 1'b0;

  wshb_if wb (.clk(clk), .rst(rst));

  wb_burst_reader #(
    .BURST_LEN (BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_m    (wb),
    .start   (start),
    .base_adr(base_adr),
    .word_cnt(word_cnt),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory contents seen by the slave: a fixed hash of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEF00D;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
  } beat_t;

  logic [31:0] exp_data[$];
  beat_t       exp_beat[$];
  int          exp_blen[$];

  int          rd_mode = 1;       // 0: never ready, 1: always ready, 2: random
  bit          rand_wait = 1'b0;
  int          stall_req = 0;
  bit          stall_seen = 1'b0;
  logic [31:0] stall_adr;
  logic [2:0]  stall_cti;
  int          beats_acked = 0;
  int          win_beats = 0;
  bit          prev_cyc = 1'b0;
  beat_t       mon_b;

  // Consumer, Wishbone slave and bus monitor, all on the falling edge.
  always @(negedge clk) begin
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
    wb.ack = 1'b0;
    if (rst) begin
      win_beats = 0;
      prev_cyc  = 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        chk("pop_expected", 64'(exp_data.size() != 0), 1);
        if (exp_data.size() != 0) chk("rd_data", rd_data, exp_data.pop_front());
      end
      if (wb.cyc && wb.stb) begin
        if (stall_req > 0) begin
          if (stall_seen) begin
            chk("stall_adr", wb.adr, stall_adr);
            chk("stall_cti", wb.cti, stall_cti);
          end else begin
            stall_seen = 1'b1;
            stall_adr  = wb.adr;
            stall_cti  = wb.cti;
          end
          stall_req--;
        end else if (rand_wait && $urandom_range(0, 3) == 0) begin
          wb.ack = 1'b0;
        end else begin
          if (stall_seen) begin
            chk("post_stall_adr", wb.adr, stall_adr);
            chk("post_stall_cti", wb.cti, stall_cti);
            stall_seen = 1'b0;
          end
          wb.ack    = 1'b1;
          wb.dat_sm = mem_word(wb.adr);
          beats_acked++;
          win_beats++;
          chk("bus_const", {wb.we, wb.sel, wb.bte}, {1'b0, 4'hF, 2'b00});
          chk("beat_expected", 64'(exp_beat.size() != 0), 1);
          if (exp_beat.size() != 0) begin
            mon_b = exp_beat.pop_front();
            chk("beat_adr", wb.adr, mon_b.adr);
            chk("beat_cti", wb.cti, mon_b.cti);
          end
        end
      end else if (stall_seen) begin
        chk("stb_held_in_stall", wb.cyc & wb.stb, 1);
        stall_seen = 1'b0;
      end
      if (prev_cyc && !wb.cyc) begin
        chk("burst_expected", 64'(exp_blen.size() != 0), 1);
        if (exp_blen.size() != 0) chk("burst_len", win_beats, exp_blen.pop_front());
        win_beats = 0;
      end
      prev_cyc = wb.cyc;
    end
  end

  // Load the reference model for a transfer and pulse start.
  task automatic begin_xfer(input logic [31:0] base, input int n);
    logic [31:0] a;
    logic [2:0]  c;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      int p, bl;
      p  = i % BURST_LEN;
      bl = (n - (i - p) < BURST_LEN) ? n - (i - p) : BURST_LEN;
      c  = (p == bl - 1) ? CTI_EOB : CTI_INCR;
      exp_data.push_back(mem_word(a + 32'(4 * i)));
      exp_beat.push_back('{adr: a + 32'(4 * i), cti: c});
    end
    for (int s = 0; s < n; s += BURST_LEN)
      exp_blen.push_back((n - s < BURST_LEN) ? n - s : BURST_LEN);
    @(posedge clk); #1;
    start    = 1'b1;
    base_adr = base;
    word_cnt = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 64'(n != 0));
  endtask

  // Wait for done, then for the stream to drain, and check the model is empty.
  task automatic finish_xfer(input int bound);
    int t;
    t = 0;
    while (!done && t < bound) begin @(posedge clk); #1; t++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    t = 0;
    while (exp_data.size() != 0 && t < bound) begin @(posedge clk); #1; t++; end
    chk("stream_drained", exp_data.size(), 0);
    chk("all_beats_seen", exp_beat.size(), 0);
    chk("all_bursts_seen", exp_blen.size(), 0);
    chk("fifo_empty_after", rd_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0, t, cyc_cnt;
    wb.ack    = 1'b0;
    wb.dat_sm = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc_stb_we", {wb.cyc, wb.stb, wb.we}, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_sel_cti_bte", {wb.sel, wb.cti, wb.bte}, {4'hF, 3'b000, 2'b00});
    chk("rst_dat_ms", wb.dat_ms, 0);
    chk("rst_outputs", {busy, done, rd_valid}, 0);
    rst = 1'b0;

    // Single beat, with start-to-cyc and ack-to-valid latency.
    rd_mode = 1; rand_wait = 1'b0;
    begin_xfer(32'h100, 1);
    chk("lat_cyc_low", wb.cyc, 0);
    @(posedge clk); #1;
    chk("lat_cyc_high", wb.cyc, 1);
    chk("lat_cti_eob", wb.cti, CTI_EOB);
    chk("lat_valid_low", rd_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_high", rd_valid, 1);
    chk("single_data", rd_data, 32'hCAFEF00D);
    finish_xfer(100);

    // Reset in the middle of a burst, then recovery.
    begin_xfer(32'h200, 16);
    t = 0;
    while (!wb.cyc && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc_stb", {wb.cyc, wb.stb}, 0);
    chk("mid_rst_valid_busy", {rd_valid, busy}, 0);
    exp_data.delete(); exp_beat.delete(); exp_blen.delete();
    stall_req = 0; stall_seen = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    begin_xfer(32'h104, 1);
    finish_xfer(100);

    // 20 words split 8/8/4.
    begin_xfer(32'h0, 20);
    finish_xfer(500);

    // Back-pressure: only a full FIFO's worth is fetched until the consumer runs.
    rd_mode = 0;
    b0 = beats_acked;
    begin_xfer(32'h1000, 40);
    repeat (150) begin @(posedge clk); #1; end
    chk("bp_beats_buffered", beats_acked - b0, FIFO_DEPTH);
    chk("bp_cyc_low", wb.cyc, 0);
    chk("bp_busy", busy, 1);
    chk("bp_valid", rd_valid, 1);
    rd_mode = 1;
    finish_xfer(500);

    // Zero word count.
    begin_xfer(32'h40, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    cyc_cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (wb.cyc) cyc_cnt++; end
    chk("zero_no_cyc", cyc_cnt, 0);
    chk("zero_done_once", done, 0);

    // Start while busy is ignored.
    begin_xfer(32'h2000, 20);
    repeat (4) begin @(posedge clk); #1; end
    chk("ign_busy", busy, 1);
    start = 1'b1; base_adr = 32'h8000; word_cnt = CNT_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    finish_xfer(500);
    cyc_cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (wb.cyc) cyc_cnt++; end
    chk("ign_no_extra_xfer", cyc_cnt, 0);

    // Slave withholds ack for three cycles mid-burst.
    b0 = beats_acked;
    begin_xfer(32'h3000, 16);
    t = 0;
    while (beats_acked - b0 < 3 && t < 100) begin @(posedge clk); #1; t++; end
    stall_req = 3;
    finish_xfer(500);
    chk("stall_consumed", stall_req, 0);

    // Address wrap at the top of the 32-bit space, unaligned base.
    begin_xfer(32'hFFFF_FFF6, 5);
    finish_xfer(500);

    // Randomized transfers with random waits and consumer stalls.
    rand_wait = 1'b1; rd_mode = 2;
    for (int k = 0; k < 10; k++) begin
      begin_xfer($urandom, int'($urandom_range(1, 45)));
      finish_xfer(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone master that reads a contiguous word region from a Wishbone slave (e.g. the BlockRAM or SDRAM controller) using incrementing bursts.
- Data is buffered in an internal FIFO and delivered on a valid/ready stream.
- Sits between the memory bus and stream consumers (video pixel fetch, DMA-style copy engines).
- Programmed by a start pulse carrying base address and word count.

Parameters:
- BURST_LEN, 8, maximum beats per Wishbone burst (power of 2, >=1)
- FIFO_DEPTH, 32, stream FIFO depth in words (power of 2, >= BURST_LEN)
- CNT_W, 16, width of word-count input

Ports:
- clk  in  1  system clock, same net as wb_m.clk
- rst  in  1  asynchronous active-high reset, same net as wb_m.rst
- wb_m  master modport  wshb_if  Wishbone bus: cyc, stb, we, adr[31:0], sel[3:0], cti[2:0], bte[1:0], dat_ms[31:0] out; ack, dat_sm[31:0] in
- start  in  1  one-cycle pulse; latches base_adr and word_cnt
- base_adr  in  32  byte address of first word (bits [1:0] ignored, forced 0)
- word_cnt  in  CNT_W  number of 32-bit words to read
- busy  out  1  high from accepted start until last word written into FIFO
- done  out  1  one-cycle pulse when the last word enters the FIFO
- rd_data  out  32  stream data (FIFO head)
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  consumer pop; a pop occurs when rd_valid && rd_ready

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: cyc=stb=0, we=0, adr=0, sel=4'hF, cti=3'b000, bte=2'b00, dat_ms=0, busy=0, done=0, rd_valid=0 (FIFO emptied). Reset mid-burst drops cyc/stb immediately; pending acks are ignored.
- we is constantly 0; sel is constantly 4'hF; bte is constantly 2'b00 (linear burst).
- FSM states: IDLE, WAIT_SPACE, BURST, GAP.
- IDLE: on start, latch adr=base_adr&~3 and rem=word_cnt.
  - If word_cnt==0: pulse done next cycle, stay IDLE, busy stays 0.
  - Otherwise set busy=1 and go to WAIT_SPACE.
- WAIT_SPACE: compute blen=min(rem, BURST_LEN). When FIFO free slots >= blen + (words already committed), assert cyc=stb=1 and go to BURST. This rule guarantees every ack can be absorbed and ack is never back-pressured.
- BURST:
  - cti=3'b010 while more than one beat remains in the burst; cti=3'b111 on the final beat (including blen==1).
  - On each cycle with ack: push dat_sm into the FIFO, adr+=4 (32-bit wrap mod 2^32), decrement beat and rem counters.
  - stb stays high without ack; adr and cti are held stable.
  - On ack of the final beat: drop cyc/stb at the next edge. If rem==0, pulse done, clear busy, go to IDLE; else go to GAP.
- GAP: one cycle with cyc=0 (lets other masters arbitrate), then WAIT_SPACE.
- start while busy is ignored.
- FIFO: simultaneous push and pop allowed when full or empty.
  - Read is first-word-fall-through: rd_data is valid in the same cycle rd_valid is high.
  - Free-slot count is updated the cycle after a pop.
  - Pop when empty has no effect.
- Latency: start to cyc high is 2 cycles when the FIFO is empty. First rd_valid occurs one cycle after the first ack.

Decomposition:
- Package wb_burst_pkg:
  - cti constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
  - BTE_LINEAR=2'b00
  - typedef enum state_t {IDLE, WAIT_SPACE, BURST, GAP}
- Sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, async active-high reset.

Test Plan:
- Reset mid-burst, then recovery:
  - Assert rst while cyc=1 -> same cycle cyc=stb=0, rd_valid=0, busy=0.
  - After release, a start with word_cnt=1 completes normally.
- Single-beat read:
  - Memory preloaded adr 0x100=0xCAFEF00D; start with base_adr=0x100, word_cnt=1 -> one cycle with cti=111, rd_data=0xCAFEF00D, done pulse, busy falls.
- Burst split:
  - base_adr=0x0, word_cnt=20, BURST_LEN=8, rd_ready=1 -> bursts of 8, 8, 4 beats; cti=010 on beats 1-7 and 111 on beat 8 (bursts of 8), 111 on beat 4 (last burst).
  - One cyc-low gap between bursts; 20 words emerge in address order.
- FIFO back-pressure:
  - rd_ready=0, word_cnt=40, FIFO_DEPTH=32 -> cyc stays low once fewer than 8 slots are free; exactly 32 words buffered, no lost ack.
  - Raising rd_ready resumes bursts; all 40 words delivered in order.
- Zero count and ignored start:
  - word_cnt=0 -> done pulses, cyc never asserts.
  - A second start while busy -> no change to adr or rem.
- Slave wait states:
  - Slave withholds ack for 3 cycles mid-burst -> adr and cti stay stable, stb stays high, no duplicate FIFO push.
